harness_exit_monitor: RTL and testbench

Synthesizable end-of-test monitor for multi-chip simulation and emulation harnesses. It snoops the write port of each chip's wide SPM and detects writes to the mailbox field (top 32 bits of the last SRAM word). It decodes exit codes per chip, aggregates them into a single done/pass/fail verdict, and runs a cycle-count watchdog. This replaces ad-hoc finish blocks in harness code, works for N chips, and also runs on FPGA.

---
 rtl/harness_exit_pkg.sv | 20 ++
 rtl/harness_exit_chan.sv | 71 +++++++
 rtl/harness_exit_monitor.sv | 124 ++++++++++++
 tb/tb_harness_exit_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_exit_pkg.sv
// Shared types and constants for the harness end-of-test monitor.
package harness_exit_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_PASS = 2'd2,
      CH_FAIL = 2'd3
   } ch_state_e;

   typedef enum logic [1:0] {
      G_IDLE  = 2'd0,
      G_ARMED = 2'd1,
      G_DONE  = 2'd2
   } glob_state_e;

   localparam logic [31:0] DefPassCode = 32'd1;
   localparam int unsigned MboxWidth   = 32;

endpackage

// File: rtl/harness_exit_chan.sv
// One monitored chip: mailbox hit decode, chip FSM and latched exit code.
module harness_exit_chan
   import harness_exit_pkg::*;
#(
   parameter int unsigned AddrWidth   = 14,
   parameter int unsigned DataWidth   = 512,
   parameter int unsigned MailboxAddr = 2**AddrWidth-1,
   parameter logic [31:0] PassCode    = DefPassCode
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   active_i,
   input  logic                   wr_valid_i,
   input  logic [AddrWidth-1:0]   wr_addr_i,
   input  logic [DataWidth-1:0]   wr_data_i,
   input  logic [DataWidth/8-1:0] wr_be_i,
   output ch_state_e              state_o,
   output logic [MboxWidth-1:0]   code_o,
   output logic                   run_d_o,
   output logic                   fail_set_o
);

   localparam int unsigned BeW = DataWidth/8;

   ch_state_e state_q, state_d;
   logic [MboxWidth-1:0] code_q, code_d;
   logic [MboxWidth-1:0] code;
   logic hit;
   logic unused_ok;

   assign code = wr_data_i[DataWidth-1 -: MboxWidth];
   assign hit  = wr_valid_i
              && (wr_addr_i == AddrWidth'(MailboxAddr))
              && (&wr_be_i[BeW-1 -: 4]);
   assign unused_ok = ^{wr_data_i, wr_be_i};

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      fail_set_o = 1'b0;
      if (clear_i) begin
         state_d = CH_RUN;
         code_d  = '0;
      end else if (active_i && hit && state_q == CH_RUN
                   && code != '0) begin
         code_d = code;
         if (code == PassCode) begin
            state_d = CH_PASS;
         end else begin
            state_d    = CH_FAIL;
            fail_set_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CH_IDLE;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
      end
   end

   assign state_o = state_q;
   assign code_o  = code_q;
   assign run_d_o = (state_d == CH_RUN);

endmodule

// File: rtl/harness_exit_monitor.sv
// End-of-test monitor: per-chip mailbox snooping, verdict aggregation
// and a cycle-count watchdog.
module harness_exit_monitor
   import harness_exit_pkg::*;
#(
   parameter int unsigned NumChips      = 1,
   parameter int unsigned AddrWidth     = 14,
   parameter int unsigned DataWidth     = 512,
   parameter int unsigned MailboxAddr   = 2**AddrWidth-1,
   parameter logic [31:0] PassCode      = DefPassCode,
   parameter int unsigned TimeoutCycles = 0,
   parameter int unsigned CntWidth      = 32
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [NumChips-1:0]             wr_valid_i,
   input  logic [NumChips*AddrWidth-1:0]   wr_addr_i,
   input  logic [NumChips*DataWidth-1:0]   wr_data_i,
   input  logic [NumChips*DataWidth/8-1:0] wr_be_i,
   output logic [NumChips*2-1:0]           ch_state_o,
   output logic [NumChips*32-1:0]          exit_code_o,
   output logic                            done_o,
   output logic                            pass_o,
   output logic                            fail_o,
   output logic                            timeout_o,
   output logic [$clog2(NumChips):0]       first_fail_o,
   output logic [CntWidth-1:0]             cycles_o
);

   localparam int unsigned FfW = $clog2(NumChips) + 1;
   localparam int unsigned BeW = DataWidth/8;
   localparam logic [CntWidth-1:0] ToLast = CntWidth'(TimeoutCycles - 1);

   glob_state_e g_q, g_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic to_q, to_d;
   logic [FfW-1:0] ff_q, ff_d, ff_idx;
   logic active, to_hit;
   logic [NumChips-1:0] run_q, run_d, fail_set, pass_v;
   ch_state_e st [NumChips];

   assign active = (g_q == G_ARMED) && !start_i;

   for (genvar c = 0; c < NumChips; c++) begin : g_chan
      harness_exit_chan #(
         .AddrWidth   (AddrWidth),
         .DataWidth   (DataWidth),
         .MailboxAddr (MailboxAddr),
         .PassCode    (PassCode)
      ) u_chan (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clear_i    (start_i),
         .active_i   (active),
         .wr_valid_i (wr_valid_i[c]),
         .wr_addr_i  (wr_addr_i[c*AddrWidth +: AddrWidth]),
         .wr_data_i  (wr_data_i[c*DataWidth +: DataWidth]),
         .wr_be_i    (wr_be_i[c*BeW +: BeW]),
         .state_o    (st[c]),
         .code_o     (exit_code_o[c*32 +: 32]),
         .run_d_o    (run_d[c]),
         .fail_set_o (fail_set[c])
      );
      assign ch_state_o[c*2 +: 2] = st[c];
      assign run_q[c]  = (st[c] == CH_RUN);
      assign pass_v[c] = (st[c] == CH_PASS);
   end

   assign to_hit = (TimeoutCycles != 0) && (cnt_q == ToLast);

   always_comb begin
      ff_idx = '1;
      for (int c = NumChips - 1; c >= 0; c--) begin
         if (fail_set[c]) ff_idx = FfW'(c);
      end
   end

   // A timeout only fires if some chip is still running after this edge.
   always_comb begin
      g_d   = g_q;
      cnt_d = cnt_q;
      to_d  = to_q;
      ff_d  = ff_q;
      if (start_i) begin
         g_d   = G_ARMED;
         cnt_d = '0;
         to_d  = 1'b0;
         ff_d  = '1;
      end else if (g_q == G_ARMED) begin
         if (ff_q == '1 && |fail_set) ff_d = ff_idx;
         if (cnt_q != '1) cnt_d = cnt_q + CntWidth'(1);
         if (!(|run_q)) begin
            g_d = G_DONE;
         end else if (to_hit && |run_d) begin
            g_d   = G_DONE;
            to_d  = 1'b1;
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         g_q   <= G_IDLE;
         cnt_q <= '0;
         to_q  <= 1'b0;
         ff_q  <= '1;
      end else begin
         g_q   <= g_d;
         cnt_q <= cnt_d;
         to_q  <= to_d;
         ff_q  <= ff_d;
      end
   end

   assign done_o       = (g_q == G_DONE);
   assign pass_o       = done_o && !to_q && (&pass_v);
   assign fail_o       = done_o && !pass_o;
   assign timeout_o    = to_q;
   assign first_fail_o = ff_q;
   assign cycles_o     = cnt_q;

endmodule

// File: tb/tb_harness_exit_monitor.sv
// Directed bench for harness_exit_monitor: 4 chips, 64-bit words,
// watchdog at 100 cycles.
module tb_harness_exit_monitor;

   localparam int NC = 4;
   localparam int AW = 14;
   localparam int DW = 64;
   localparam int BW = DW/8;
   localparam logic [AW-1:0] MB = 14'd16383;
   localparam logic [127:0] ONES4 = {32'd1, 32'd1, 32'd1, 32'd1};
   localparam logic [127:0] NINES = {32'd9, 32'd9, 32'd9, 32'd9};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [NC-1:0] wv = '0;
   logic [NC*AW-1:0] wa = '0;
   logic [NC*DW-1:0] wd = '0;
   logic [NC*BW-1:0] wb = '0;
   logic [NC*2-1:0] ch_state;
   logic [NC*32-1:0] codes;
   logic done, pass, fail, tmo;
   logic [2:0] ff;
   logic [31:0] cycles;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   harness_exit_monitor #(
      .NumChips      (NC),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .TimeoutCycles (100),
      .CntWidth      (32)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .wr_valid_i   (wv),
      .wr_addr_i    (wa),
      .wr_data_i    (wd),
      .wr_be_i      (wb),
      .ch_state_o   (ch_state),
      .exit_code_o  (codes),
      .done_o       (done),
      .pass_o       (pass),
      .fail_o       (fail),
      .timeout_o    (tmo),
      .first_fail_o (ff),
      .cycles_o     (cycles)
   );

   typedef struct {
      logic           s;
      logic [3:0]     v;
      logic [AW-1:0]  a;
      logic [BW-1:0]  be;
      logic [127:0]   cd;
      logic [7:0]     e_st;
      logic           e_done;
      logic           e_pass;
      logic           e_fail;
      logic [2:0]     e_ff;
      logic [127:0]   e_code;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [3:0] v,
                        input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [127:0] cd);
      start = s;
      wv    = v;
      for (int c = 0; c < NC; c++) begin
         wa[c*AW +: AW] = a;
         wb[c*BW +: BW] = be;
         wd[c*DW +: DW] = {cd[c*32 +: 32], 32'h5a5a_0000 | 32'(c)};
      end
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, '0, '0, '0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // start pass-all, late write, then mixed fail, then ignored hits
      tbl[0]  = '{1'b1, 4'h0, MB, 8'hFF, 128'h0,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[1]  = '{1'b0, 4'hF, MB, 8'hFF, ONES4,
                  8'hAA, 1'b0, 1'b0, 1'b0, 3'd7, ONES4};
      tbl[2]  = '{1'b0, 4'h0, 14'd0, 8'h00, 128'h0,
                  8'hAA, 1'b1, 1'b1, 1'b0, 3'd7, ONES4};
      tbl[3]  = '{1'b0, 4'hF, MB, 8'hFF, NINES,
                  8'hAA, 1'b1, 1'b1, 1'b0, 3'd7, ONES4};
      tbl[4]  = '{1'b1, 4'h0, 14'd0, 8'h00, 128'h0,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[5]  = '{1'b0, 4'h5, MB, 8'hFF, ONES4,
                  8'h66, 1'b0, 1'b0, 1'b0, 3'd7,
                  {32'd0, 32'd1, 32'd0, 32'd1}};
      tbl[6]  = '{1'b0, 4'hA, MB, 8'hFF, {32'd7, 32'd0, 32'd5, 32'd0},
                  8'hEE, 1'b0, 1'b0, 1'b0, 3'd1,
                  {32'd7, 32'd1, 32'd5, 32'd1}};
      tbl[7]  = '{1'b0, 4'h0, 14'd0, 8'h00, 128'h0,
                  8'hEE, 1'b1, 1'b0, 1'b1, 3'd1,
                  {32'd7, 32'd1, 32'd5, 32'd1}};
      tbl[8]  = '{1'b1, 4'h0, 14'd0, 8'h00, 128'h0,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[9]  = '{1'b0, 4'hF, MB, 8'hFF, 128'h0,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[10] = '{1'b0, 4'hF, 14'd100, 8'hFF, ONES4,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[11] = '{1'b0, 4'hF, MB, 8'hC0, ONES4,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};
      tbl[12] = '{1'b0, 4'h0, 14'd0, 8'h00, 128'h0,
                  8'h55, 1'b0, 1'b0, 1'b0, 3'd7, 128'h0};

      idle();
      #12;
      chk("rst state", 128'(ch_state), 128'h0);
      chk("rst done", 128'(done), 128'h0);
      chk("rst pass", 128'(pass), 128'h0);
      chk("rst fail", 128'(fail), 128'h0);
      chk("rst timeout", 128'(tmo), 128'h0);
      chk("rst ff", 128'(ff), 128'h7);
      chk("rst cycles", 128'(cycles), 128'h0);
      chk("rst codes", 128'(codes), 128'h0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].s, tbl[i].v, tbl[i].a, tbl[i].be, tbl[i].cd);
         step();
         chk($sformatf("v%0d state", i), 128'(ch_state), 128'(tbl[i].e_st));
         chk($sformatf("v%0d done", i), 128'(done), 128'(tbl[i].e_done));
         chk($sformatf("v%0d pass", i), 128'(pass), 128'(tbl[i].e_pass));
         chk($sformatf("v%0d fail", i), 128'(fail), 128'(tbl[i].e_fail));
         chk($sformatf("v%0d ff", i), 128'(ff), 128'(tbl[i].e_ff));
         chk($sformatf("v%0d codes", i), 128'(codes), tbl[i].e_code);
      end

      // start and hit on the same edge, first code wins, re-arm
      drive(1'b1, 4'hF, MB, 8'hFF, ONES4);
      step();
      chk("sh state", 128'(ch_state), 128'h55);
      chk("sh codes", 128'(codes), 128'h0);
      drive(1'b0, 4'hF, MB, 8'hFF, ONES4);
      step();
      chk("rp pass state", 128'(ch_state), 128'hAA);
      drive(1'b0, 4'hF, MB, 8'hFF, NINES);
      step();
      chk("rp first wins", 128'(codes), ONES4);
      idle();
      step();
      chk("rp done", 128'(done), 128'h1);
      chk("rp pass", 128'(pass), 128'h1);
      drive(1'b1, 4'h0, '0, '0, '0);
      step();
      chk("rs state", 128'(ch_state), 128'h55);
      chk("rs done", 128'(done), 128'h0);
      chk("rs pass", 128'(pass), 128'h0);
      chk("rs codes", 128'(codes), 128'h0);
      chk("rs cycles", 128'(cycles), 128'h0);
      drive(1'b0, 4'h1, MB, 8'hFF, NINES);
      step();
      chk("rs fail state", 128'(ch_state), 128'h57);
      chk("rs fail code", 128'(codes[31:0]), 128'd9);
      chk("rs ff", 128'(ff), 128'h0);

      // watchdog with no writes
      drive(1'b1, 4'h0, '0, '0, '0);
      step();
      idle();
      chk("to cyc0", 128'(cycles), 128'h0);
      chk("to ff clr", 128'(ff), 128'h7);
      repeat (99) step();
      chk("to pre done", 128'(done), 128'h0);
      chk("to pre cycles", 128'(cycles), 128'd99);
      chk("to pre tmo", 128'(tmo), 128'h0);
      step();
      chk("to tmo", 128'(tmo), 128'h1);
      chk("to done", 128'(done), 128'h1);
      chk("to fail", 128'(fail), 128'h1);
      chk("to pass", 128'(pass), 128'h0);
      chk("to state", 128'(ch_state), 128'h55);
      step();
      chk("to frozen", 128'(cycles), 128'd99);

      // last hit on the watchdog edge wins over the timeout
      drive(1'b1, 4'h0, '0, '0, '0);
      step();
      drive(1'b0, 4'h7, MB, 8'hFF, ONES4);
      step();
      idle();
      repeat (98) step();
      chk("th cycles", 128'(cycles), 128'd99);
      drive(1'b0, 4'h8, MB, 8'hFF, ONES4);
      step();
      idle();
      chk("th tmo", 128'(tmo), 128'h0);
      chk("th state", 128'(ch_state), 128'hAA);
      chk("th done early", 128'(done), 128'h0);
      step();
      chk("th done", 128'(done), 128'h1);
      chk("th pass", 128'(pass), 128'h1);
      chk("th tmo2", 128'(tmo), 128'h0);

      // asynchronous reset mid-run
      drive(1'b1, 4'h0, '0, '0, '0);
      step();
      drive(1'b0, 4'h3, MB, 8'hFF, ONES4);
      step();
      idle();
      chk("ar pre state", 128'(ch_state), 128'h5A);
      #3 rst = 1'b1;
      #1;
      chk("ar state", 128'(ch_state), 128'h0);
      chk("ar codes", 128'(codes), 128'h0);
      chk("ar ff", 128'(ff), 128'h7);
      chk("ar cycles", 128'(cycles), 128'h0);
      chk("ar done", 128'(done), 128'h0);
      #2 rst = 1'b0;
      drive(1'b0, 4'hF, MB, 8'hFF, ONES4);
      step();
      idle();
      chk("ar idle hit state", 128'(ch_state), 128'h0);
      chk("ar idle hit codes", 128'(codes), 128'h0);
      step();
      chk("ar idle done", 128'(done), 128'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
